// File: rtl/speed_pi_controller.sv
// speed_pi_controller: sampled PI speed loop producing a PWM duty command.
// Ports: clk_in/reset_in, clk_en strobe, enable_in, target/actual rpm in;
//   duty_out, duty_valid_out pulse, saturated_out, busy_out.
module speed_pi_controller #(
  parameter int KP        = 4,
  parameter int KI        = 1,
  parameter int SHIFT     = 2,
  parameter int INT_LIMIT = 4000,
  parameter int DUTY_W    = 10
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              clk_en,
  input  logic              enable_in,
  input  logic [9:0]        target_rpm_in,
  input  logic [9:0]        actual_rpm_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_valid_out,
  output logic              saturated_out,
  output logic              busy_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_MULT, S_SUM, S_CLAMP
  } state_t;

  localparam logic signed [16:0] LIM_P = 17'(INT_LIMIT);
  localparam logic signed [16:0] LIM_N = -LIM_P;
  localparam logic signed [19:0] KP_S  = 20'(KP);
  localparam logic signed [24:0] KI_S  = 25'(KI);
  localparam logic signed [24:0] U_MAX = 25'((1 << DUTY_W) - 1);

  state_t r_state;
  state_t w_next;

  logic [9:0]         r_tgt;
  logic [9:0]         r_act;
  logic signed [10:0] r_err;
  logic signed [15:0] r_integ;
  logic signed [19:0] r_p;
  logic signed [24:0] r_i;
  logic signed [24:0] r_u;
  logic [DUTY_W-1:0]  r_duty;
  logic               r_valid;
  logic               r_sat_hi;
  logic               r_sat_lo;
  logic               r_sat_out;
  logic               r_en_d;

  logic signed [10:0] w_err;
  logic signed [16:0] w_isum;
  logic signed [16:0] w_iclamp;
  logic               w_hold;
  logic signed [19:0] w_p;
  logic signed [24:0] w_i;
  logic signed [24:0] w_sum;

  assign w_err = $signed({1'b0, r_tgt}) - $signed({1'b0, r_act});

  assign w_isum = $signed({r_integ[15], r_integ})
                + $signed({{6{w_err[10]}}, w_err});

  assign w_iclamp = (w_isum > LIM_P) ? LIM_P :
                    (w_isum < LIM_N) ? LIM_N : w_isum;

  // Anti-windup: stop integrating further into a rail hit last update
  assign w_hold = (r_sat_hi && !w_err[10] && (w_err != 11'sd0))
               || (r_sat_lo && w_err[10]);

  assign w_p = KP_S * $signed({{9{r_err[10]}}, r_err});
  assign w_i = KI_S * $signed({{9{r_integ[15]}}, r_integ});

  assign w_sum = $signed({{5{r_p[19]}}, r_p}) + r_i;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!enable_in) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (clk_en) w_next = S_ERR;
        S_ERR:   w_next = S_MULT;
        S_MULT:  w_next = S_SUM;
        S_SUM:   w_next = S_CLAMP;
        S_CLAMP: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_tgt     <= '0;
      r_act     <= '0;
      r_err     <= '0;
      r_integ   <= '0;
      r_p       <= '0;
      r_i       <= '0;
      r_u       <= '0;
      r_duty    <= '0;
      r_valid   <= 1'b0;
      r_sat_hi  <= 1'b0;
      r_sat_lo  <= 1'b0;
      r_sat_out <= 1'b0;
      r_en_d    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_en_d  <= enable_in;
      if (!enable_in) begin
        r_integ   <= '0;
        r_sat_hi  <= 1'b0;
        r_sat_lo  <= 1'b0;
        r_duty    <= '0;
        r_sat_out <= 1'b0;
        // Announce the forced zero once, on the falling enable only
        r_valid   <= r_en_d;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (clk_en) begin
              r_tgt <= target_rpm_in;
              r_act <= actual_rpm_in;
            end
          end
          S_ERR: begin
            r_err <= w_err;
            if (!w_hold) r_integ <= w_iclamp[15:0];
          end
          S_MULT: begin
            r_p <= w_p;
            r_i <= w_i;
          end
          S_SUM: begin
            r_u <= w_sum >>> SHIFT;
          end
          S_CLAMP: begin
            r_valid <= 1'b1;
            if (r_u[24]) begin
              r_duty    <= '0;
              r_sat_lo  <= 1'b1;
              r_sat_hi  <= 1'b0;
              r_sat_out <= 1'b1;
            end else if (r_u > U_MAX) begin
              r_duty    <= '1;
              r_sat_lo  <= 1'b0;
              r_sat_hi  <= 1'b1;
              r_sat_out <= 1'b1;
            end else begin
              r_duty    <= r_u[DUTY_W-1:0];
              r_sat_lo  <= 1'b0;
              r_sat_hi  <= 1'b0;
              r_sat_out <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign duty_out       = r_duty;
  assign duty_valid_out = r_valid;
  assign saturated_out  = r_sat_out;
  assign busy_out       = (r_state != S_IDLE);

endmodule
